// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//
// UART receive engine. It detects the start edge on an oversampled line,
// samples each bit at mid-period, and checks the configured parity and stop
// bits. Accepted frames are presented on a valid/ready handshake. Parity,
// framing and overrun conditions are reported as single-cycle pulses.
//
// Parameters
//   DATA_BITS    data bits per frame (5..9), LSB first
//   OVERSAMPLE   baud_tick_i pulses per bit period (even, 8..32)
//   PARITY_MODE  0 = none, 1 = even, 2 = odd
//   STOP_BITS    stop bits checked per frame (1 or 2)
//
// Optional feature macro
//   UART_RX_BREAK_DET_EN  adds brk_o and a BREAK state. A frame whose data
//                         bits, parity bit and first stop bit are all zero
//                         pulses brk_o instead of frame_err_o. The engine
//                         then waits for the line to be idle for a full bit
//                         period before it accepts another start edge.
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   baud_tick_i    one-clk strobe at OVERSAMPLE x baud rate
//   rxd_i          asynchronous serial line, idle high
//   rx_data_o      received data word
//   rx_valid_o     rx_data_o holds an unconsumed frame
//   rx_ready_i     consumer accepts rx_data_o while rx_valid_o is high
//   parity_err_o   pulse: frame dropped because of a parity mismatch
//   frame_err_o    pulse: a stop bit was sampled low
//   overrun_err_o  pulse: good frame lost because rx_valid_o was still set
//   brk_o          pulse: break frame detected (UART_RX_BREAK_DET_EN only)
//   busy_o         high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_rx_core #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 baud_tick_i,
  input  logic                 rxd_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_err_o,
`ifdef UART_RX_BREAK_DET_EN
  output logic                 brk_o,
`endif
  output logic                 busy_o
);

  localparam int SCNT_W = $clog2(OVERSAMPLE);
  localparam int BCNT_W = 4;

  localparam logic [SCNT_W-1:0] SCNT_HALF = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(DATA_BITS - 1);
  localparam logic [BCNT_W-1:0] STOP_LAST = BCNT_W'(STOP_BITS - 1);
  localparam logic              ODD_PAR   = (PARITY_MODE == 2);

`ifdef UART_RX_BREAK_DET_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`endif

  state_e                state_q;
  logic                  sync1_q;
  logic                  rxs_q;
  logic                  rxs_prev_q;
  logic [SCNT_W-1:0]     scnt_q;
  logic [BCNT_W-1:0]     bcnt_q;
  logic [DATA_BITS-1:0]  shreg_q;
  logic                  perr_q;
  logic                  ferr_q;
  logic                  done_q;
  logic [DATA_BITS-1:0]  rx_data_q;
  logic                  rx_valid_q;
  logic                  parity_err_q;
  logic                  frame_err_q;
  logic                  overrun_err_q;
  logic                  busy_q;

  logic [SCNT_W-1:0]     scnt_inc_d;
  logic [BCNT_W-1:0]     bcnt_inc_d;
  logic [DATA_BITS-1:0]  shreg_d;
  logic                  mid_tick;
  logic                  bit_tick;
  logic                  par_ok;

`ifdef UART_RX_BREAK_DET_EN
  logic                  par_bit_q;
  logic                  stop0_zero_q;
  logic                  brk_hit_q;
  logic                  brk_q;
  logic                  first_stop_zero;
  logic                  brk_now;
`endif

  // Sampling strobes and next-value helpers shared by the FSM.
  always_comb begin
    scnt_inc_d = scnt_q + 1'b1;
    bcnt_inc_d = bcnt_q + 1'b1;
    // Start bit is checked half a bit after the edge; every later bit is
    // checked one full bit period after the previous sample.
    mid_tick   = baud_tick_i && (scnt_q == SCNT_HALF);
    bit_tick   = baud_tick_i && (scnt_q == SCNT_LAST);
    shreg_d    = {rxs_q, shreg_q[DATA_BITS-1:1]};
    // XOR of all data bits and the parity bit: 0 for even, 1 for odd.
    par_ok     = ((^shreg_q) ^ rxs_q) == ODD_PAR;
  end

`ifdef UART_RX_BREAK_DET_EN
  // With a single stop bit the first stop bit is the sample being taken now.
  always_comb begin
    first_stop_zero = (bcnt_q == '0) ? !rxs_q : stop0_zero_q;
    brk_now         = (shreg_q == '0) && ((PARITY_MODE == 0) || !par_bit_q)
                      && first_stop_zero;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b1;
      rxs_q         <= 1'b1;
      rxs_prev_q    <= 1'b1;
      scnt_q        <= '0;
      bcnt_q        <= '0;
      shreg_q       <= '0;
      perr_q        <= 1'b0;
      ferr_q        <= 1'b0;
      done_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      par_bit_q     <= 1'b0;
      stop0_zero_q  <= 1'b0;
      brk_hit_q     <= 1'b0;
      brk_q         <= 1'b0;
`endif
    end else begin
      // Two-flop synchroniser plus one history flop for edge detection.
      sync1_q       <= rxd_i;
      rxs_q         <= sync1_q;
      rxs_prev_q    <= rxs_q;

      done_q        <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk_q         <= 1'b0;
`endif

      case (state_q)
        IDLE: begin
          // Requires a real 1->0 transition, so a line stuck low is ignored.
          if (rxs_prev_q && !rxs_q) begin
            scnt_q  <= '0;
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          if (mid_tick) begin
            scnt_q <= '0;
            if (!rxs_q) begin
              bcnt_q  <= '0;
              perr_q  <= 1'b0;
              ferr_q  <= 1'b0;
              state_q <= DATA;
            end else begin
              // Start bit gone by mid-bit: glitch, silently drop it.
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (baud_tick_i) begin
            scnt_q <= scnt_inc_d;
          end
        end

        DATA: begin
          if (bit_tick) begin
            scnt_q  <= '0;
            shreg_q <= shreg_d;
            if (bcnt_q == DATA_LAST) begin
              bcnt_q  <= '0;
              state_q <= (PARITY_MODE == 0) ? STOP : PARITY;
            end else begin
              bcnt_q <= bcnt_inc_d;
            end
          end else if (baud_tick_i) begin
            scnt_q <= scnt_inc_d;
          end
        end

        PARITY: begin
          if (bit_tick) begin
            scnt_q    <= '0;
            perr_q    <= !par_ok;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_q <= rxs_q;
`endif
            bcnt_q    <= '0;
            state_q   <= STOP;
          end else if (baud_tick_i) begin
            scnt_q <= scnt_inc_d;
          end
        end

        STOP: begin
          if (bit_tick) begin
            scnt_q <= '0;
            ferr_q <= ferr_q | !rxs_q;
`ifdef UART_RX_BREAK_DET_EN
            if (bcnt_q == '0) begin
              stop0_zero_q <= !rxs_q;
            end
`endif
            if (bcnt_q == STOP_LAST) begin
              // Frame finished; the verdict is applied on the next clk while
              // the FSM is already free to look for the next start edge.
              bcnt_q  <= '0;
              done_q  <= 1'b1;
`ifdef UART_RX_BREAK_DET_EN
              brk_hit_q <= brk_now;
              if (brk_now) begin
                state_q <= BREAK;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
`else
              state_q <= IDLE;
              busy_q  <= 1'b0;
`endif
            end else begin
              bcnt_q <= bcnt_inc_d;
            end
          end else if (baud_tick_i) begin
            scnt_q <= scnt_inc_d;
          end
        end

`ifdef UART_RX_BREAK_DET_EN
        BREAK: begin
          // scnt counts consecutive high ticks; any low tick restarts it.
          if (baud_tick_i) begin
            if (!rxs_q) begin
              scnt_q <= '0;
            end else if (scnt_q == SCNT_LAST) begin
              scnt_q  <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              scnt_q <= scnt_inc_d;
            end
          end
        end
`endif

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Handshake. A load in the same cycle below overrides this clear, which
      // gives the consume-and-reload behaviour on a simultaneous completion.
      if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end

      if (done_q) begin
`ifdef UART_RX_BREAK_DET_EN
        if (brk_hit_q) begin
          brk_q <= 1'b1;
        end else
`endif
        if (ferr_q) begin
          frame_err_q <= 1'b1;
        end else if (perr_q) begin
          parity_err_q <= 1'b1;
        end else if (rx_valid_q && !rx_ready_i) begin
          overrun_err_q <= 1'b1;
        end else begin
          rx_data_q  <= shreg_q;
          rx_valid_q <= 1'b1;
        end
      end
    end
  end

  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign parity_err_o  = parity_err_q;
  assign frame_err_o   = frame_err_q;
  assign overrun_err_o = overrun_err_q;
  assign busy_o        = busy_q;
`ifdef UART_RX_BREAK_DET_EN
  assign brk_o         = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
//
// Directed bench for uart_rx_core. Two instances: the default configuration
// (8 data bits, OVERSAMPLE=16, even parity, 1 stop bit) and a 7-bit,
// odd-parity, 2-stop-bit configuration. baud_tick is one clk in four, so a
// bit period is 64 clks. Pulse outputs are counted by negedge monitors.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] div = 2'd0;
  logic       baud_tick;

  always #5 clk = ~clk;
  always @(posedge clk) div <= div + 2'd1;
  assign baud_tick = (div == 2'd3);

  // Default instance
  logic       rxd, rx_ready, rx_valid, parity_err, frame_err, overrun_err, busy;
  logic [7:0] rx_data;
  // 7-bit / odd / 2-stop instance
  logic       rxd7, rx_ready7, rx_valid7, parity_err7, frame_err7, overrun_err7, busy7;
  logic [6:0] rx_data7;
`ifdef UART_RX_BREAK_DET_EN
  logic       brk, brk7;
`endif

  uart_rx_core dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .baud_tick_i   (baud_tick),
    .rxd_i         (rxd),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (rx_ready),
    .parity_err_o  (parity_err),
    .frame_err_o   (frame_err),
    .overrun_err_o (overrun_err),
`ifdef UART_RX_BREAK_DET_EN
    .brk_o         (brk),
`endif
    .busy_o        (busy)
  );

  uart_rx_core #(
    .DATA_BITS   (7),
    .OVERSAMPLE  (16),
    .PARITY_MODE (2),
    .STOP_BITS   (2)
  ) dut7 (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .baud_tick_i   (baud_tick),
    .rxd_i         (rxd7),
    .rx_data_o     (rx_data7),
    .rx_valid_o    (rx_valid7),
    .rx_ready_i    (rx_ready7),
    .parity_err_o  (parity_err7),
    .frame_err_o   (frame_err7),
    .overrun_err_o (overrun_err7),
`ifdef UART_RX_BREAK_DET_EN
    .brk_o         (brk7),
`endif
    .busy_o        (busy7)
  );

  // Pulse / activity monitors
  int         v_cyc, pe_n, fe_n, ov_n, brk_n, busy_seen;
  int         v7_cyc, pe7_n, fe7_n, ov7_n;
  logic [7:0] cap;
  logic [6:0] cap7;

  always @(negedge clk) begin
    if (rx_valid)     begin v_cyc++; cap = rx_data; end
    if (parity_err)   pe_n++;
    if (frame_err)    fe_n++;
    if (overrun_err)  ov_n++;
    if (busy)         busy_seen = 1;
    if (rx_valid7)    begin v7_cyc++; cap7 = rx_data7; end
    if (parity_err7)  pe7_n++;
    if (frame_err7)   fe7_n++;
    if (overrun_err7) ov7_n++;
`ifdef UART_RX_BREAK_DET_EN
    if (brk)          brk_n++;
`endif
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    v_cyc = 0; pe_n = 0; fe_n = 0; ov_n = 0; brk_n = 0; busy_seen = 0;
    v7_cyc = 0; pe7_n = 0; fe7_n = 0; ov7_n = 0;
  endtask

  // Every drive happens 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit1(input logic b);
    rxd = b;
    step(BIT);
  endtask

  task automatic bit7(input logic b);
    rxd7 = b;
    step(BIT);
  endtask

  task automatic send8(input logic [7:0] d, input logic p, input logic s);
    bit1(1'b0);
    for (int i = 0; i < 8; i++) bit1(d[i]);
    bit1(p);
    bit1(s);
    rxd = 1'b1;
    step(2 * BIT);
  endtask

  task automatic send7(input logic [6:0] d, input logic p, input logic s1, input logic s2);
    bit7(1'b0);
    for (int i = 0; i < 7; i++) bit7(d[i]);
    bit7(p);
    bit7(s1);
    bit7(s2);
    rxd7 = 1'b1;
    step(2 * BIT);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d33;
    logic [6:0] d2a;
    int         got;

    rst_n = 1'b0; rxd = 1'b1; rxd7 = 1'b1; rx_ready = 1'b1; rx_ready7 = 1'b0;
    clr();
    step(3);

    // Reset state
    chk("rst_rx_data",  32'(rx_data), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_busy",     32'(busy), 32'h0);
    chk("rst_errs",     32'({parity_err, frame_err, overrun_err}), 32'h0);
    rst_n = 1'b1;
    step(4);

    // Good frame 0xA5, even parity bit 0, ready held high
    clr();
    send8(8'hA5, 1'b0, 1'b1);
    chk("a5_valid_cycles", 32'(v_cyc), 32'd1);
    chk("a5_data",         32'(cap), 32'hA5);
    chk("a5_errs",         32'(pe_n + fe_n + ov_n), 32'd0);
    chk("a5_valid_now",    32'(rx_valid), 32'h0);

    // 0x3C with wrong parity bit
    clr();
    send8(8'h3C, 1'b1, 1'b1);
    chk("3c_parity_err", 32'(pe_n), 32'd1);
    chk("3c_valid",      32'(v_cyc), 32'd0);
    chk("3c_data_keep",  32'(rx_data), 32'hA5);
    chk("3c_other_errs", 32'(fe_n + ov_n), 32'd0);

    // Start glitch: low for 5 ticks then high
    clr();
    rxd = 1'b0;
    step(20);
    rxd = 1'b1;
    step(24);
    chk("glitch_busy_seen", 32'(busy_seen), 32'd1);
    chk("glitch_busy_end",  32'(busy), 32'h0);
    chk("glitch_no_out",    32'(v_cyc + pe_n + fe_n + ov_n), 32'd0);
    step(BIT);

    // 0x55 with low stop bit
    clr();
    send8(8'h55, 1'b0, 1'b0);
    chk("55_frame_err", 32'(fe_n), 32'd1);
    chk("55_valid",     32'(v_cyc), 32'd0);
    chk("55_parity",    32'(pe_n), 32'd0);
    chk("55_data_keep", 32'(rx_data), 32'hA5);

    // All-zero frame: break when enabled, framing error otherwise
    clr();
`ifdef UART_RX_BREAK_DET_EN
    bit1(1'b0);
    for (int i = 0; i < 8; i++) bit1(1'b0);
    bit1(1'b0);
    bit1(1'b0);
    rxd = 1'b1;
    step(40);
    chk("brk_busy_hold", 32'(busy), 32'h1);
    step(40);
    chk("brk_busy_end",  32'(busy), 32'h0);
    chk("brk_pulse",     32'(brk_n), 32'd1);
    chk("brk_no_fe",     32'(fe_n), 32'd0);
    step(BIT);
`else
    send8(8'h00, 1'b0, 1'b0);
    chk("zero_frame_err", 32'(fe_n), 32'd1);
    chk("zero_valid",     32'(v_cyc), 32'd0);
    chk("zero_busy",      32'(busy), 32'h0);
`endif

    // Overrun: consumer stalled
    rx_ready = 1'b0;
    clr();
    send8(8'h11, 1'b0, 1'b1);
    chk("11_valid", 32'(rx_valid), 32'h1);
    chk("11_data",  32'(rx_data), 32'h11);
    chk("11_no_ov", 32'(ov_n), 32'd0);
    send8(8'h22, 1'b0, 1'b1);
    chk("22_overrun",   32'(ov_n), 32'd1);
    chk("22_data_keep", 32'(rx_data), 32'h11);
    chk("22_valid",     32'(rx_valid), 32'h1);

    // 0x33 completes in the same cycle the consumer accepts 0x11
    clr();
    d33 = 8'h33;
    bit1(1'b0);
    for (int i = 0; i < 8; i++) bit1(d33[i]);
    bit1(1'b0);
    rxd = 1'b1;
    got = 0;
    for (int i = 0; i < 3 * BIT && got == 0; i++) begin
      step(1);
      if (!busy) got = 1;
    end
    chk("33_stop_seen", 32'(got), 32'd1);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    chk("33_data",  32'(rx_data), 32'h33);
    chk("33_valid", 32'(rx_valid), 32'h1);
    step(BIT);
    chk("33_no_ov", 32'(ov_n), 32'd0);
    rx_ready = 1'b1;
    step(2);
    chk("33_drained", 32'(rx_valid), 32'h0);

    // 7-bit odd parity, 2 stop bits
    clr();
    send7(7'h12, 1'b1, 1'b1, 1'b1);
    chk("7_12_valid", 32'(rx_valid7), 32'h1);
    chk("7_12_data",  32'(rx_data7), 32'h12);
    chk("7_12_errs",  32'(pe7_n + fe7_n + ov7_n), 32'd0);
    clr();
    send7(7'h41, 1'b1, 1'b1, 1'b0);
    chk("7_41_frame_err", 32'(fe7_n), 32'd1);
    chk("7_41_no_pe_ov",  32'(pe7_n + ov7_n), 32'd0);
    chk("7_41_data_keep", 32'(rx_data7), 32'h12);

    // Reset in the middle of the data bits
    clr();
    d2a = 7'h2A;
    bit7(1'b0);
    for (int i = 0; i < 3; i++) bit7(d2a[i]);
    rxd7 = d2a[3];
    step(BIT / 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy7",  32'(busy7), 32'h0);
    chk("mid_rst_valid7", 32'(rx_valid7), 32'h0);
    chk("mid_rst_data7",  32'(rx_data7), 32'h0);
    chk("mid_rst_data",   32'(rx_data), 32'h0);
    rxd7 = 1'b1;
    step(4);
    rst_n = 1'b1;
    step(BIT);
    chk("mid_rst_no_err", 32'(pe7_n + fe7_n + ov7_n), 32'd0);

    clr();
    rx_ready7 = 1'b1;
    send7(7'h5B, 1'b0, 1'b1, 1'b1);
    chk("7_5b_valid_cycles", 32'(v7_cyc), 32'd1);
    chk("7_5b_data",         32'(cap7), 32'h5B);
    chk("7_5b_errs",         32'(pe7_n + fe7_n + ov7_n), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
